// File: rtl/game_fsm.sv
// game_fsm -- turn controller for a two-player grid shooting game.
//
// Maps the mouse cursor onto the target grid and turns clicks into shots.
// Shots go out over a valid/ready link, and the block waits for the
// hit/miss result. Incoming enemy shots are answered with the own-board
// lookup. The block counts hits both ways and declares the winner.
//
// Optional feature: define GAME_FSM_TURN_TIMEOUT_EN to add a per-turn
// frame timer. It forfeits the turn (timeout_pass) after TURN_FRAMES
// frames spent in AIM.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   frame_tick                one pulse per video frame (timer only)
//   start, first_player       start/restart; 1 = this side fires first
//   mouse_left/xpos/ypos      mouse button level and pixel position
//   ships_placed              own cells placed so far
//   shot_valid/addr/ready     outgoing shot handshake
//   res_valid, res_hit        result of our shot
//   rx_valid, rx_addr         incoming enemy shot
//   own_hit                   own-board lookup of rx_addr, same cycle
//   resp_valid, resp_hit      reply to the enemy shot
//   cursor_addr/valid         hovered cell {row, col}
//   timeout_pass              turn-forfeit pulse
//   state_code, state_led     state number and its one-hot form
//   hits_made/taken, win/lose score and outcome
module game_fsm #(
   parameter int BOARD_N     = 10,
   parameter int CELL_PX     = 32,
   parameter int BOARD_X0    = 608,
   parameter int BOARD_Y0    = 193,
   parameter int SHIP_CELLS  = 11,
   parameter int HIT_AGAIN   = 1,
   parameter int TURN_FRAMES = 600,
   localparam int CW         = $clog2(BOARD_N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_tick,
   input  logic            start,
   input  logic            first_player,
   input  logic            mouse_left,
   input  logic [11:0]     mouse_xpos,
   input  logic [11:0]     mouse_ypos,
   input  logic [3:0]      ships_placed,
   output logic            shot_valid,
   output logic [2*CW-1:0] shot_addr,
   input  logic            shot_ready,
   input  logic            res_valid,
   input  logic            res_hit,
   input  logic            rx_valid,
   input  logic [2*CW-1:0] rx_addr,
   input  logic            own_hit,
   output logic            resp_valid,
   output logic            resp_hit,
   output logic [2*CW-1:0] cursor_addr,
   output logic            cursor_valid,
   output logic            timeout_pass,
   output logic [2:0]      state_code,
   output logic [7:0]      state_led,
   output logic [3:0]      hits_made,
   output logic [3:0]      hits_taken,
   output logic            win,
   output logic            lose
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PLACE  = 3'd1,
      S_AIM    = 3'd2,
      S_SHOT   = 3'd3,
      S_RESULT = 3'd4,
      S_WAIT   = 3'd5,
      S_WIN    = 3'd6,
      S_LOSE   = 3'd7
   } state_t;

   localparam int          PX_SH = $clog2(CELL_PX);
   localparam logic [12:0] X_LO  = 13'(BOARD_X0);
   localparam logic [12:0] X_HI  = 13'(BOARD_X0 + BOARD_N * CELL_PX);
   localparam logic [12:0] Y_LO  = 13'(BOARD_Y0);
   localparam logic [12:0] Y_HI  = 13'(BOARD_Y0 + BOARD_N * CELL_PX);
   localparam logic [3:0]  SHIPS = 4'(SHIP_CELLS);

   state_t     state, state_n;
   logic [11:0] dx, dy;
   logic        in_x, in_y;
   logic        mouse_q, mouse_q2;
   logic        click, aim_fire, expire;
   logic        made_inc, taken_inc, clr_cnt;
   logic        made_full, taken_full;

   // ---------------- cursor mapping and click detection ----------------
   // Offsets wrap when the pointer is left of or above the grid. That is
   // harmless because cursor_valid is computed separately from the
   // unsigned range test.
   always_comb begin
      dx   = mouse_xpos - X_LO[11:0];
      dy   = mouse_ypos - Y_LO[11:0];
      in_x = ({1'b0, mouse_xpos} >= X_LO) && ({1'b0, mouse_xpos} < X_HI);
      in_y = ({1'b0, mouse_ypos} >= Y_LO) && ({1'b0, mouse_ypos} < Y_HI);
   end

   // NOTE: state elements use non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cursor_addr  <= '0;
         cursor_valid <= 1'b0;
         mouse_q      <= 1'b0;
         mouse_q2     <= 1'b0;
      end else begin
         cursor_addr  <= {CW'(dy >> PX_SH), CW'(dx >> PX_SH)};
         cursor_valid <= in_x && in_y;
         mouse_q      <= mouse_left;
         mouse_q2     <= mouse_q;
      end
   end

   // One click per press: a held button produces only the first edge.
   assign click    = mouse_q && !mouse_q2;
   assign aim_fire = (state == S_AIM) && click && cursor_valid;

   // ---------------- optional turn timer ----------------
`ifdef GAME_FSM_TURN_TIMEOUT_EN
   localparam int TW = $clog2(TURN_FRAMES + 1);
   logic [TW-1:0] turn_timer;

   assign expire = (state == S_AIM) && frame_tick &&
                   (turn_timer == TW'(TURN_FRAMES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         turn_timer   <= '0;
         timeout_pass <= 1'b0;
      end else begin
         // A click arriving on the expiry frame takes priority.
         timeout_pass <= expire && !aim_fire;
         if (state != S_AIM)
            turn_timer <= '0;
         else if (frame_tick)
            turn_timer <= turn_timer + 1'b1;
      end
   end
`else
   wire unused_frame_tick = frame_tick;
   assign expire       = 1'b0;
   assign timeout_pass = 1'b0;
`endif

   // ---------------- next state ----------------
   assign made_full  = ({1'b0, hits_made}  + 5'd1) >= {1'b0, SHIPS};
   assign taken_full = ({1'b0, hits_taken} + 5'd1) >= {1'b0, SHIPS};

   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_n   = state;
      made_inc  = 1'b0;
      taken_inc = 1'b0;
      clr_cnt   = 1'b0;
      case (state)
         S_IDLE:   if (start) state_n = S_PLACE;
         S_PLACE:  if (ships_placed == SHIPS)
                      state_n = first_player ? S_AIM : S_WAIT;
         S_AIM:    if (aim_fire)    state_n = S_SHOT;
                   else if (expire) state_n = S_WAIT;
         S_SHOT:   if (shot_ready) state_n = S_RESULT;
         S_RESULT: if (res_valid) begin
                      if (res_hit) begin
                         made_inc = 1'b1;
                         if (made_full)           state_n = S_WIN;
                         else if (HIT_AGAIN != 0) state_n = S_AIM;
                         else                     state_n = S_WAIT;
                      end else begin
                         state_n = S_WAIT;
                      end
                   end
         S_WAIT:   if (rx_valid) begin
                      if (own_hit) begin
                         taken_inc = 1'b1;
                         if (taken_full)          state_n = S_LOSE;
                         else if (HIT_AGAIN != 0) state_n = S_WAIT;
                         else                     state_n = S_AIM;
                      end else begin
                         state_n = S_AIM;
                      end
                   end
         S_WIN, S_LOSE: if (start) begin
                      clr_cnt = 1'b1;
                      state_n = S_IDLE;
                   end
         default:  state_n = S_IDLE;
      endcase
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         shot_addr  <= '0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         hits_made  <= '0;
         hits_taken <= '0;
      end else begin
         state      <= state_n;
         resp_valid <= (state == S_WAIT) && rx_valid;
         if (aim_fire)
            shot_addr <= cursor_addr;
         if ((state == S_WAIT) && rx_valid)
            resp_hit <= own_hit;
         if (clr_cnt)
            hits_made <= '0;
         else if (made_inc && (hits_made < SHIPS))
            hits_made <= hits_made + 4'd1;
         if (clr_cnt)
            hits_taken <= '0;
         else if (taken_inc && (hits_taken < SHIPS))
            hits_taken <= hits_taken + 4'd1;
      end
   end

   // Decoded from the state register, so reset drops shot_valid at once.
   assign shot_valid = (state == S_SHOT);
   assign win        = (state == S_WIN);
   assign lose       = (state == S_LOSE);
   assign state_code = state;
   assign state_led  = 8'd1 << state;

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm -- self-checking bench for game_fsm.
// Covers a cursor-mapping vector table, directed turn sequences, timeout
// behaviour (with or without GAME_FSM_TURN_TIMEOUT_EN) and randomized whole
// games. The randomized games are checked against a score/turn model.
module tb_game_fsm;

   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            frame_tick, start, first_player, mouse_left;
   logic [11:0]     mouse_xpos, mouse_ypos;
   logic [3:0]      ships_placed;
   logic            shot_valid, shot_ready;
   logic [2*CW-1:0] shot_addr, rx_addr, cursor_addr;
   logic            res_valid, res_hit, rx_valid, own_hit;
   logic            resp_valid, resp_hit, cursor_valid, timeout_pass;
   logic [2:0]      state_code;
   logic [7:0]      state_led;
   logic [3:0]      hits_made, hits_taken;
   logic            win, lose;

   int n_checks = 0;
   int n_fail   = 0;

   // model of the game: scores and whose turn it is
   int m_made, m_taken;
   bit m_our;

   always #5 clk = ~clk;

   game_fsm #(.TURN_FRAMES(3)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .first_player(first_player), .mouse_left(mouse_left),
      .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
      .ships_placed(ships_placed), .shot_valid(shot_valid),
      .shot_addr(shot_addr), .shot_ready(shot_ready),
      .res_valid(res_valid), .res_hit(res_hit), .rx_valid(rx_valid),
      .rx_addr(rx_addr), .own_hit(own_hit), .resp_valid(resp_valid),
      .resp_hit(resp_hit), .cursor_addr(cursor_addr),
      .cursor_valid(cursor_valid), .timeout_pass(timeout_pass),
      .state_code(state_code), .state_led(state_led),
      .hits_made(hits_made), .hits_taken(hits_taken),
      .win(win), .lose(lose)
   );

   typedef struct {
      int         x;
      int         y;
      logic       valid;
      logic [7:0] addr;
   } cur_vec_t;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic click_at(input int x, input int y);
      mouse_xpos = 12'(x);
      mouse_ypos = 12'(y);
      mouse_left = 1'b0;
      tick(); tick();
      mouse_left = 1'b1;
      tick(); tick();
      mouse_left = 1'b0;
   endtask

   function automatic int exp_state();
      if (m_made >= 11)  return 6;
      if (m_taken >= 11) return 7;
      return m_our ? 2 : 5;
   endfunction

   task automatic check_model(input string tag);
      check({tag, " state"}, state_code, exp_state());
      check({tag, " hits_made"}, hits_made, m_made);
      check({tag, " hits_taken"}, hits_taken, m_taken);
      check({tag, " win"}, win, m_made >= 11);
      check({tag, " lose"}, lose, m_taken >= 11);
   endtask

   // start from IDLE; ships_placed is already complete
   task automatic start_game(input bit fp);
      first_player = fp;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   // our shot at pixel (x,y): click, handshake after `delay` stalls, result
   task automatic fire(input int x, input int y, input int delay,
                       input bit hit);
      int exp_addr;
      exp_addr = ((y - 193) / 32) * 16 + (x - 608) / 32;
      click_at(x, y);
      check("fire state SHOT", state_code, 3);
      check("fire shot_addr", shot_addr, exp_addr);
      for (int i = 0; i < delay; i++) begin
         tick();
         check("fire stall shot_valid", shot_valid, 1);
         check("fire stall shot_addr", shot_addr, exp_addr);
      end
      shot_ready = 1'b1;
      tick();
      shot_ready = 1'b0;
      check("fire state RESULT", state_code, 4);
      check("fire shot_valid drop", shot_valid, 0);
      res_valid = 1'b1;
      res_hit   = hit;
      tick();
      res_valid = 1'b0;
      res_hit   = 1'b0;
   endtask

   task automatic enemy(input logic [7:0] addr, input bit hit);
      rx_valid = 1'b1;
      rx_addr  = addr;
      own_hit  = hit;
      tick();
      rx_valid = 1'b0;
      own_hit  = 1'b0;
      check("enemy resp_valid", resp_valid, 1);
      check("enemy resp_hit", resp_hit, hit);
      tick();
      check("enemy resp_valid pulse", resp_valid, 0);
   endtask

   initial begin
      cur_vec_t cvec[7];
      cvec[0] = '{608, 193, 1'b1, 8'h00};
      cvec[1] = '{927, 193, 1'b1, 8'h09};
      cvec[2] = '{928, 193, 1'b0, 8'h00};
      cvec[3] = '{607, 200, 1'b0, 8'h00};
      cvec[4] = '{640, 225, 1'b1, 8'h11};
      cvec[5] = '{927, 512, 1'b1, 8'h99};
      cvec[6] = '{700, 513, 1'b0, 8'h00};

      rst = 1'b1; frame_tick = 0; start = 0; first_player = 0;
      mouse_left = 0; mouse_xpos = 0; mouse_ypos = 0; ships_placed = 4'd11;
      shot_ready = 0; res_valid = 0; res_hit = 0; rx_valid = 0;
      rx_addr = 0; own_hit = 0;
      tick(); tick();

      // reset state
      check("rst state", state_code, 0);
      check("rst led", state_led, 8'h01);
      check("rst shot_valid", shot_valid, 0);
      check("rst shot_addr", shot_addr, 0);
      check("rst resp_valid", resp_valid, 0);
      check("rst counters", {hits_made, hits_taken}, 0);
      check("rst win/lose", {win, lose}, 0);
      check("rst timeout", timeout_pass, 0);
      check("rst cursor", {cursor_valid, cursor_addr}, 0);
      rst = 1'b0;
      tick();

      // cursor mapping, 1-cycle latency
      foreach (cvec[i]) begin
         mouse_xpos = 12'(cvec[i].x);
         mouse_ypos = 12'(cvec[i].y);
         tick();
         check($sformatf("cursor_valid %0d", i), cursor_valid, cvec[i].valid);
         if (cvec[i].valid)
            check($sformatf("cursor_addr %0d", i), cursor_addr, cvec[i].addr);
      end

      // IDLE -> PLACE -> AIM
      first_player = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("place state", state_code, 1);
      tick();
      check("aim state", state_code, 2);
      check("aim led", state_led, 8'h04);

      // start and res_valid ignored in AIM
      start = 1'b1; tick(); start = 1'b0;
      check("start ignored in AIM", state_code, 2);
      res_valid = 1'b1; res_hit = 1'b1; tick(); res_valid = 0; res_hit = 0;
      check("res ignored in AIM", hits_made, 0);
      check("res ignored state", state_code, 2);

      // shot held stable while shot_ready is low
      fire(640, 225, 5, 1'b1);
      check("hit -> AIM", state_code, 2);
      check("hits_made 1", hits_made, 1);
      for (int k = 2; k <= 11; k++) begin
         fire(608 + 32 * (k % 10), 193 + 32 * (k / 10), 0, 1'b1);
         check($sformatf("hits_made %0d", k), hits_made, k);
      end
      check("win state", state_code, 6);
      check("win flag", win, 1);
      check("win led", state_led, 8'h40);
      start = 1'b1; tick(); start = 1'b0;
      check("restart idle", state_code, 0);
      check("restart counters", {hits_made, hits_taken}, 0);
      check("restart win", win, 0);

      // turn timeout
      start_game(1'b1);
      check("aim again", state_code, 2);
      for (int f = 0; f < 3; f++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
`ifdef GAME_FSM_TURN_TIMEOUT_EN
         if (f < 2) begin
            check("timer counting state", state_code, 2);
            check("timer counting pass", timeout_pass, 0);
         end else begin
            check("timeout state", state_code, 5);
            check("timeout pulse", timeout_pass, 1);
         end
`else
         check("no timer state", state_code, 2);
         check("no timer pass", timeout_pass, 0);
`endif
         tick();
         check("timeout pass low", timeout_pass, 0);
      end
`ifdef GAME_FSM_TURN_TIMEOUT_EN
      enemy(8'h33, 1'b0);
      check("timeout back to AIM", state_code, 2);
`endif

      // ignored inputs in AIM
      rx_valid = 1'b1; rx_addr = 8'h12; own_hit = 1'b1;
      tick();
      rx_valid = 1'b0; own_hit = 1'b0;
      check("rx in AIM resp", resp_valid, 0);
      check("rx in AIM state", state_code, 2);
      check("rx in AIM taken", hits_taken, 0);
      click_at(100, 100);
      check("off-board click", state_code, 2);
      // press off-board, slide onto the grid while held: no click
      mouse_xpos = 12'd100; mouse_ypos = 12'd100; mouse_left = 1'b1;
      tick(); tick();
      mouse_xpos = 12'd640; mouse_ypos = 12'd225;
      tick(); tick(); tick();
      check("held level no click", state_code, 2);
      mouse_left = 1'b0;
      tick();

      // miss -> WAIT, enemy hit stays, enemy miss -> AIM
      fire(700, 300, 1, 1'b0);
      check("miss -> WAIT", state_code, 5);
      check("miss hits_made", hits_made, 0);
      res_valid = 1'b1; res_hit = 1'b1; tick(); res_valid = 0; res_hit = 0;
      check("res in WAIT ignored", hits_made, 0);
      enemy(8'h23, 1'b1);
      check("enemy hit state", state_code, 5);
      check("enemy hit taken", hits_taken, 1);
      enemy(8'h45, 1'b0);
      check("enemy miss state", state_code, 2);

      // lose path and saturation
      fire(700, 300, 0, 1'b0);
      for (int k = 2; k <= 11; k++) begin
         enemy(8'(k), 1'b1);
         check($sformatf("hits_taken %0d", k), hits_taken, k);
      end
      check("lose state", state_code, 7);
      check("lose flag", lose, 1);
      check("lose led", state_led, 8'h80);
      rx_valid = 1'b1; own_hit = 1'b1; tick(); rx_valid = 0; own_hit = 0;
      check("lose saturate", hits_taken, 11);
      check("lose no resp", resp_valid, 0);
      start = 1'b1; tick(); start = 1'b0;
      check("lose restart", state_code, 0);
      check("lose restart taken", hits_taken, 0);

      // reset during SHOT drops shot_valid without a clock edge
      start_game(1'b1);
      click_at(640, 225);
      check("pre-reset shot_valid", shot_valid, 1);
      rst = 1'b1;
      #1;
      check("async rst shot_valid", shot_valid, 0);
      check("async rst state", state_code, 0);
      tick();
      rst = 1'b0;
      tick();

      // randomized games against the model
      for (int g = 0; g < 4; g++) begin
         bit fp;
         fp = 1'($urandom_range(0, 1));
         start_game(fp);
         m_made = 0; m_taken = 0; m_our = fp;
         check_model("game start");
         for (int ev = 0; ev < 300; ev++) begin
            bit hit;
            hit = ($urandom_range(0, 9) < 6);
            if (m_our) begin
               if ($urandom_range(0, 3) == 0) begin
                  rx_valid = 1'b1; rx_addr = 8'($urandom); own_hit = 1'b1;
                  tick();
                  rx_valid = 1'b0; own_hit = 1'b0;
                  check("rand rx ignored", resp_valid, 0);
               end
               fire(608 + int'($urandom_range(0, 319)),
                    193 + int'($urandom_range(0, 319)),
                    int'($urandom_range(0, 3)), hit);
               if (hit) m_made++;
               else     m_our = 1'b0;
            end else begin
               if ($urandom_range(0, 3) == 0) begin
                  res_valid = 1'b1; res_hit = 1'b1;
                  tick();
                  res_valid = 1'b0; res_hit = 1'b0;
               end
               enemy(8'($urandom), hit);
               if (hit) m_taken++;
               else     m_our = 1'b1;
            end
            check_model("rand");
            if (m_made >= 11 || m_taken >= 11) break;
         end
         start = 1'b1; tick(); start = 1'b0;
         check("rand restart state", state_code, 0);
         check("rand restart counters", {hits_made, hits_taken}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
